word_serializer: RTL and testbench

//   Parametrised word-to-symbol serialiser: accepts WORD_W-bit words on a valid/ready

---
 rtl/word_serializer.sv | 95 +++++++++
 tb/tb_word_serializer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// word_serializer: buffers words in a small FIFO and emits them as SYM_W-bit symbols, LSB- or MSB-first
module word_serializer #(
   parameter int WORD_W    = 16,
   parameter int SYM_W     = 8,
   parameter int DEPTH     = 2,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ce,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WORD_W-1:0]             in_word,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [SYM_W-1:0]              out_sym,
   output logic                          out_first,
   output logic                          out_last,
   output logic [$clog2(DEPTH+2)-1:0]    level
);
   localparam int N  = WORD_W / SYM_W;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int LW = $clog2(DEPTH + 2);

   if ((WORD_W % SYM_W) != 0 || N < 2 || DEPTH < 1) begin : g_param_check
      $error("word_serializer: WORD_W must be a multiple of SYM_W, N >= 2, DEPTH >= 1");
   end

   logic [N-1:0][SYM_W-1:0] mem [DEPTH];
   logic [N-1:0][SYM_W-1:0] hold;
   logic                    hold_valid;
   logic [IW-1:0]           idx;
   logic [IW-1:0]           sel;
   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           rd_ptr;
   logic [CW-1:0]           count;
   logic                    acc;
   logic                    snd;
   logic                    last;
   logic                    hold_free;
   logic                    pop;
   logic                    bypass;
   logic                    push;

   // in_ready looks only at the registered FIFO count, so a full FIFO stays closed during its pop cycle
   assign in_ready  = ce & rst_n & (count != CW'(DEPTH));
   assign out_valid = ce & hold_valid;
   assign acc       = in_valid & in_ready;
   assign snd       = out_valid & out_ready;
   assign last      = idx == IW'(N - 1);
   assign hold_free = ~hold_valid | (snd & last);
   assign pop       = hold_free & (count != '0);
   assign bypass    = acc & hold_free & (count == '0);
   assign push      = acc & ~bypass;
   assign sel       = MSB_FIRST ? IW'(N - 1) - idx : idx;
   assign out_sym   = out_valid ? hold[sel] : '0;
   assign out_first = out_valid & (idx == '0);
   assign out_last  = out_valid & last;
   assign level     = LW'(count) + LW'(hold_valid);

   // FIFO storage needs no reset: entries are only read after being written
   always_ff @(posedge clk) begin
      if (ce & push) mem[wr_ptr] <= in_word;
   end

   // pointers, count and holding register; the holding register reloads from the FIFO head first, else bypasses in_word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         hold       <= '0;
         hold_valid <= 1'b0;
         idx        <= '0;
      end else if (ce) begin
         if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         if (pop) begin
            hold       <= mem[rd_ptr];
            hold_valid <= 1'b1;
            idx        <= '0;
         end else if (bypass) begin
            hold       <= in_word;
            hold_valid <= 1'b1;
            idx        <= '0;
         end else if (snd) begin
            hold_valid <= ~last;
            idx        <= last ? '0 : idx + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: directed and randomized checks of word_serializer against a queue-based model
module tb_word_serializer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        ce, in_valid, in_ready, out_valid, out_ready, out_first, out_last;
   logic [15:0] in_word;
   logic [7:0]  out_sym;
   logic [1:0]  level;
   logic        d1_ce, d1_iv, d1_ir, d1_ov, d1_or, d1_first, d1_last;
   logic [31:0] d1_w;
   logic [7:0]  d1_sym;
   logic [1:0]  d1_level;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   word_serializer #(.WORD_W(16), .SYM_W(8), .DEPTH(2), .MSB_FIRST(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
      .in_word(in_word), .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
      .out_first(out_first), .out_last(out_last), .level(level));

   word_serializer #(.WORD_W(32), .SYM_W(8), .DEPTH(2), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst_n(rst_n), .ce(d1_ce), .in_valid(d1_iv), .in_ready(d1_ir),
      .in_word(d1_w), .out_valid(d1_ov), .out_ready(d1_or), .out_sym(d1_sym),
      .out_first(d1_first), .out_last(d1_last), .level(d1_level));

   task automatic drive(input logic iv, input logic [15:0] w, input logic ordy, input logic c);
      @(negedge clk);
      in_valid = iv;
      in_word = w;
      out_ready = ordy;
      ce = c;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ce = 1'b1; in_valid = 1'b1; in_word = 16'hFFFF; out_ready = 1'b1;
      d1_ce = 1'b1; d1_iv = 1'b1; d1_w = '1; d1_or = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, out_sym, out_first, out_last, level} !== 13'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", {in_ready, out_valid, out_sym, out_first, out_last, level});
      end
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0; d1_iv = 1'b0; d1_or = 1'b0;
      drive(1'b0, 16'h0, 1'b1, 1'b1);
      checks++;
      if ({in_ready, level} !== 3'b100) begin
         failures++;
         $display("FAIL reset_release in_ready/level got=%b exp=100", {in_ready, level});
      end
   endtask

   task automatic test_single();
      drive(1'b1, 16'hA55A, 1'b1, 1'b1);
      drive(1'b0, 16'h0, 1'b1, 1'b1);
      checks++;
      if ({out_valid, out_first, out_last, out_sym, level} !== {3'b110, 8'h5A, 2'd1}) begin
         failures++;
         $display("FAIL single_sym0 got=%h exp=%h", {out_valid, out_first, out_last, out_sym, level}, {3'b110, 8'h5A, 2'd1});
      end
      drive(1'b0, 16'h0, 1'b1, 1'b1);
      checks++;
      if ({out_valid, out_first, out_last, out_sym} !== {3'b101, 8'hA5}) begin
         failures++;
         $display("FAIL single_sym1 got=%h exp=%h", {out_valid, out_first, out_last, out_sym}, {3'b101, 8'hA5});
      end
      drive(1'b0, 16'h0, 1'b1, 1'b1);
      checks++;
      if ({out_valid, out_sym, level} !== 11'h0) begin
         failures++;
         $display("FAIL single_idle got=%h exp=0", {out_valid, out_sym, level});
      end
   endtask

   task automatic test_stream();
      logic [15:0] ws [5] = '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h0000};
      logic [7:0]  ex [8] = '{8'h02, 8'h01, 8'h04, 8'h03, 8'h06, 8'h05, 8'h08, 8'h07};
      logic [7:0]  got [$];
      int i = 0;
      int first_c = -1;
      int last_c = -1;
      for (int c = 0; c < 20; c++) begin
         drive(i < 4, ws[i], 1'b1, 1'b1);
         if (in_valid && in_ready) i++;
         if (out_valid) begin
            if (first_c < 0) first_c = c;
            last_c = c;
            got.push_back(out_sym);
         end
      end
      checks++;
      if (got.size() != 8) begin
         failures++;
         $display("FAIL stream_count got=%0d exp=8", got.size());
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (k >= got.size() || got[k] !== ex[k]) begin
            failures++;
            $display("FAIL stream_sym[%0d] got=%h exp=%h", k, (k < got.size()) ? got[k] : 8'hxx, ex[k]);
         end
      end
      checks++;
      if (last_c - first_c != 7) begin
         failures++;
         $display("FAIL stream_contiguous span got=%0d exp=7", last_c - first_c);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] ws [5] = '{16'hB1A1, 16'hB2A2, 16'hB3A3, 16'hB4A4, 16'h0000};
      logic [7:0]  ex [6] = '{8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3};
      logic [7:0]  got [$];
      int i = 0;
      logic stable = 1'b1;
      logic ready_seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         drive(i < 4, ws[i], 1'b0, 1'b1);
         if (in_valid && in_ready) i++;
         if (c > 0 && {out_valid, out_first, out_sym} !== {2'b11, 8'hA1}) stable = 1'b0;
      end
      checks++;
      if (i != 3 || level !== 2'd3 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_full accepted=%0d level=%0d in_ready=%b exp 3/3/0", i, level, in_ready);
      end
      checks++;
      if (!stable) begin
         failures++;
         $display("FAIL bp_stable out_sym not held got=%h exp=a1", out_sym);
      end
      for (int c = 0; c < 10; c++) begin
         drive(1'b0, 16'h0, 1'b1, 1'b1);
         if (in_ready) ready_seen = 1'b1;
         if (out_valid) got.push_back(out_sym);
      end
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (k >= got.size() || got[k] !== ex[k]) begin
            failures++;
            $display("FAIL bp_drain_sym[%0d] got=%h exp=%h", k, (k < got.size()) ? got[k] : 8'hxx, ex[k]);
         end
      end
      checks++;
      if (got.size() != 6 || !ready_seen || level !== 2'd0) begin
         failures++;
         $display("FAIL bp_drain n=%0d ready_seen=%b level=%0d exp 6/1/0", got.size(), ready_seen, level);
      end
   endtask

   task automatic test_ce_and_reset();
      drive(1'b1, 16'hC3D4, 1'b1, 1'b1);
      drive(1'b0, 16'h0, 1'b1, 1'b1);
      checks++;
      if ({out_valid, out_first, out_last, out_sym} !== {3'b110, 8'hD4}) begin
         failures++;
         $display("FAIL ce_first got=%h exp=%h", {out_valid, out_first, out_last, out_sym}, {3'b110, 8'hD4});
      end
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 16'hFFFF, 1'b1, 1'b0);
         checks++;
         if ({in_ready, out_valid, out_first, out_last, out_sym, level} !== {12'h0, 2'd1}) begin
            failures++;
            $display("FAIL ce_frozen[%0d] got=%h exp=%h", c, {in_ready, out_valid, out_first, out_last, out_sym, level}, {12'h0, 2'd1});
         end
      end
      drive(1'b0, 16'h0, 1'b1, 1'b1);
      checks++;
      if ({out_valid, out_first, out_last, out_sym} !== {3'b101, 8'hC3}) begin
         failures++;
         $display("FAIL ce_resume got=%h exp=%h", {out_valid, out_first, out_last, out_sym}, {3'b101, 8'hC3});
      end
      drive(1'b1, 16'hE5F6, 1'b1, 1'b1);
      drive(1'b0, 16'h0, 1'b0, 1'b1);
      checks++;
      if ({out_valid, out_sym} !== {1'b1, 8'hF6}) begin
         failures++;
         $display("FAIL rst_pre got=%h exp=%h", {out_valid, out_sym}, {1'b1, 8'hF6});
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, out_sym, out_first, out_last, level} !== 13'h0) begin
         failures++;
         $display("FAIL rst_async got=%h exp=0", {in_ready, out_valid, out_sym, out_first, out_last, level});
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 16'h1234, 1'b1, 1'b1);
      drive(1'b0, 16'h0, 1'b1, 1'b1);
      checks++;
      if ({out_valid, out_first, out_last, out_sym, level} !== {3'b110, 8'h34, 2'd1}) begin
         failures++;
         $display("FAIL rst_restart got=%h exp=%h", {out_valid, out_first, out_last, out_sym, level}, {3'b110, 8'h34, 2'd1});
      end
      drive(1'b0, 16'h0, 1'b1, 1'b1);
      drive(1'b0, 16'h0, 1'b1, 1'b1);
   endtask

   task automatic test_msb_first();
      logic [31:0] w;
      for (int t = 0; t < 3; t++) begin
         w = (t == 0) ? 32'h11223344 : $urandom;
         @(negedge clk);
         d1_iv = 1'b1; d1_w = w; d1_or = 1'b1; d1_ce = 1'b1;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            d1_iv = 1'b0;
            #1;
            checks++;
            if ({d1_ov, d1_first, d1_last, d1_sym} !== {1'b1, k == 0, k == 3, 8'(w >> (8 * (3 - k)))}) begin
               failures++;
               $display("FAIL msb_sym[%0d.%0d] got=%h exp=%h", t, k, {d1_ov, d1_first, d1_last, d1_sym},
                        {1'b1, k == 0, k == 3, 8'(w >> (8 * (3 - k)))});
            end
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if ({d1_ov, d1_sym, d1_level} !== 11'h0) begin
         failures++;
         $display("FAIL msb_idle got=%h exp=0", {d1_ov, d1_sym, d1_level});
      end
   endtask

   task automatic test_random();
      logic [15:0] wq [$];
      int          sent = 0;
      logic        iv, ordy, c, e_ir, e_ov;
      logic [15:0] w;
      logic [7:0]  e_sym;
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         iv = 1'($urandom_range(0, 1));
         ordy = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 7) != 0);
         w = 16'($urandom);
         drive(iv, w, ordy, c);
         e_ir = c & (wq.size() <= 2);
         e_ov = c & (wq.size() > 0);
         e_sym = 8'h0;
         if (e_ov) e_sym = 8'(wq[0] >> (8 * sent));
         checks++;
         if ({in_ready, out_valid, out_first, out_last, out_sym, level} !==
             {e_ir, e_ov, e_ov & (sent == 0), e_ov & (sent == 1), e_sym, 2'(wq.size())}) begin
            failures++;
            $display("FAIL random[%0d] ir/ov/f/l/sym/lvl got=%b%b%b%b/%h/%0d exp=%b%b%b%b/%h/%0d", cyc,
                     in_ready, out_valid, out_first, out_last, out_sym, level,
                     e_ir, e_ov, e_ov & (sent == 0), e_ov & (sent == 1), e_sym, wq.size());
         end
         if (e_ov && ordy) begin
            sent++;
            if (sent == 2) begin
               void'(wq.pop_front());
               sent = 0;
            end
         end
         if (iv && e_ir) wq.push_back(w);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_ce_and_reset();
      test_msb_first();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
